// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_pkg
// Purpose : Shared types for the reset/clock-enable sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

    localparam int MAX_DOMAINS = 64;
    localparam int DOM_IDX_W   = $clog2(MAX_DOMAINS);

    typedef enum logic [2:0] {
        ST_GATE = 3'd0,
        ST_HOLD = 3'd1,
        ST_EN   = 3'd2,
        ST_REL  = 3'd3,
        ST_DONE = 3'd4,
        ST_RUN  = 3'd5
    } state_t;

    typedef logic [DOM_IDX_W-1:0] dom_idx_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_timer.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_timer
// Purpose : Loadable down-counter shared by the HOLD, EN and REL phases.
// Rev     : 1.0  initial release
// ============================================================================
module rst_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_clr,
    output logic             o_expired,
    output logic             o_active
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    // A cleared timer sits at zero but is not expired until it has been loaded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= i_load_val;
            r_active <= 1'b1;
        end else if (i_clr) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (r_active && (r_cnt != '0)) begin
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    assign o_expired = r_active && (r_cnt == '0);
    assign o_active  = r_active;

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rst_seq_ctrl
// Purpose : Gates all domain clocks, holds resets, then releases domains in order.
// Rev     : 1.0  initial release
// ============================================================================
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0]       c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_gap_load  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] c_one_hot0  = NUM_DOMAINS'(1);
    localparam dom_idx_t               c_last_idx  = dom_idx_t'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
        $fatal(1, "rst_seq_ctrl: NUM_DOMAINS out of range");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "rst_seq_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $fatal(1, "rst_seq_ctrl: GAP_CYCLES must be >= 1");
    end

    state_t                 r_state, w_state_nxt;
    dom_idx_t               r_idx, w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_clk_en, w_clk_en_nxt;
    logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    logic                   w_ld, w_clr, w_expired, w_active;
    logic [CNT_W-1:0]       w_ld_val;
    logic [NUM_DOMAINS-1:0] w_sel, w_sel_next;

    assign w_sel      = c_one_hot0 << r_idx;
    assign w_sel_next = w_sel << 1;

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_clr      (w_clr),
        .o_expired  (w_expired),
        .o_active   (w_active)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_HOLD;
            r_idx    <= '0;
            r_clk_en <= '0;
            r_rst_n  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_rst_n  <= w_rst_n_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_clk_en_nxt = r_clk_en;
        w_rst_n_nxt  = r_rst_n;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_ld         = 1'b0;
        w_ld_val     = '0;
        w_clr        = 1'b0;

        // Clocks are cut first; resets follow one cycle later on entry to HOLD.
        if (req_i && (r_state != ST_GATE) && (r_state != ST_HOLD)) begin
            w_state_nxt  = ST_GATE;
            w_clk_en_nxt = '0;
            w_busy_nxt   = 1'b1;
            w_clr        = 1'b1;
        end else begin
            case (r_state)
                ST_GATE: begin
                    w_state_nxt  = ST_HOLD;
                    w_clk_en_nxt = '0;
                    w_rst_n_nxt  = '0;
                    if (req_i) begin
                        w_clr    = 1'b1;
                    end else begin
                        w_ld     = 1'b1;
                        w_ld_val = c_hold_load;
                    end
                end
                ST_HOLD: begin
                    if (req_i) begin
                        w_clr        = 1'b1;
                    end else if (w_expired) begin
                        w_state_nxt  = ST_EN;
                        w_idx_nxt    = '0;
                        w_clk_en_nxt = r_clk_en | c_one_hot0;
                        w_ld         = 1'b1;
                        w_ld_val     = c_gap_load;
                    end else if (!w_active) begin
                        w_ld         = 1'b1;
                        w_ld_val     = c_hold_load;
                    end
                end
                ST_EN: begin
                    if (w_expired) begin
                        w_state_nxt = ST_REL;
                        w_rst_n_nxt = r_rst_n | w_sel;
                        w_ld        = 1'b1;
                        w_ld_val    = c_gap_load;
                    end
                end
                ST_REL: begin
                    if (w_expired) begin
                        if (r_idx == c_last_idx) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_clr       = 1'b1;
                        end else begin
                            w_state_nxt  = ST_EN;
                            w_idx_nxt    = dom_idx_t'(r_idx + 1'b1);
                            w_clk_en_nxt = r_clk_en | w_sel_next;
                            w_ld         = 1'b1;
                            w_ld_val     = c_gap_load;
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_HOLD;
            endcase
        end
    end

    assign clk_en_o = r_clk_en;
    assign rst_no   = r_rst_n;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule
`default_nettype wire
